// File: rtl/adaptor_types.sv
// Shared widths for the cacheline-to-burst memory adaptor.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package adaptor_types;
  typedef logic [255:0] line_t;
  typedef logic [31:0]  addr_t;
  typedef logic [63:0]  burst_t;
  localparam int BEATS = 4;
endpackage

// File: rtl/line_burst_adaptor.sv
// Converts one 256-bit line read/write into a 4-beat 64-bit memory burst.
// Latency: request to resp_o is 5 cycles minimum (1 accept + 4 beats), +1 per stalled beat.
// Backpressure: memory paces beats with resp_i; the arbiter holds read_i/write_i until resp_o.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   line_i/line_o       write line in / assembled read line out (held until next read completes)
//   address_i           line address, low 5 bits ignored
//   read_i/write_i      line requests, held until resp_o
//   resp_o              one-cycle completion pulse
//   burst_i/burst_o     read beat from memory / write beat to memory
//   address_o           aligned burst address
//   read_o/write_o      burst requests to memory
//   resp_i              per-beat handshake from memory
module line_burst_adaptor
  import adaptor_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic [1:0] state;
  logic [1:0] cnt;
  addr_t      addr_q;
  // Holds the write line during WRITE and collects read beats during READ.
  line_t      line_q;
  // Published read line; only updated when a read finishes, so writes leave it alone.
  line_t      rd_line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      addr_q    <= '0;
      line_q    <= '0;
      rd_line_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Write wins if the arbiter ever raises both.
          if (write_i) begin
            addr_q <= {address_i[31:5], 5'b0};
            line_q <= line_i;
            cnt    <= 2'd0;
            state  <= S_WRITE;
          end else if (read_i) begin
            addr_q <= {address_i[31:5], 5'b0};
            cnt    <= 2'd0;
            state  <= S_READ;
          end
        end
        S_READ: begin
          if (resp_i) begin
            line_q[{cnt, 6'b0} +: 64] <= burst_i;
            if (cnt == LAST_BEAT) begin
              // Final beat goes straight into the published line in the same edge.
              rd_line_q <= {burst_i, line_q[191:0]};
              state     <= S_DONE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        S_WRITE: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              state <= S_DONE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        default: begin
          // DONE: requests may still be asserted this cycle and must not restart a burst.
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign read_o    = (state == S_READ);
  assign write_o   = (state == S_WRITE);
  assign resp_o    = (state == S_DONE);
  assign address_o = addr_q;
  assign line_o    = rd_line_q;
  assign burst_o   = (state == S_WRITE) ? line_q[{cnt, 6'b0} +: 64] : 64'd0;

  // Arbiter must never present read and write together.
  always @(posedge clk) begin
    if (!rst && state == S_IDLE) begin
      assert (!(read_i && write_i))
        else $warning("line_burst_adaptor: read_i and write_i both high in IDLE");
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Randomized bench for line_burst_adaptor against a transaction-level memory model.
// Latency: checks resp_o arrives 5 cycles after request plus one per stalled beat.
// Backpressure: bench acts as memory, inserting random resp_i gaps.
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int vectors;
  int miscompares;

  // Model state: last line returned by a completed read (zero after reset).
  logic [255:0] exp_line;

  line_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // One full line transaction. For reads, 'data' is what memory returns beat by beat;
  // for writes, it is the line presented on line_i. Called in the cycle the request is driven.
  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] data,
                        input int gmin, input int gmax, input bit hold, input bit both);
    int k;
    int gap;
    int gaps_total;
    int lat;
    logic [31:0] aligned;
    aligned    = {addr[31:5], 5'b0};
    address_i  = addr;
    line_i     = is_wr ? data : rand_line();
    read_i     = !is_wr || both;
    write_i    = is_wr;
    k          = 0;
    gaps_total = 0;
    gap        = $urandom_range(gmax, gmin);
    next_cycle();
    lat = 1;
    while (k < 4 && lat < 200) begin
      check(is_wr ? "write_o busy" : "read_o busy", {254'd0, read_o, write_o},
            is_wr ? 256'd1 : 256'd2);
      check("address_o", address_o, aligned);
      check("resp_o early", resp_o, 0);
      if (is_wr) check("burst_o", burst_o, data[64*k +: 64]);
      // Scribble on the request inputs mid-burst; the latched copy must be used.
      line_i    = rand_line();
      address_i = $urandom;
      if (gap > 0) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        gap--;
        gaps_total++;
      end else begin
        resp_i  = 1'b1;
        burst_i = is_wr ? {$urandom, $urandom} : data[64*k +: 64];
        k++;
        gap = $urandom_range(gmax, gmin);
      end
      next_cycle();
      lat++;
    end
    resp_i = 1'b0;
    check("beat timeout", lat < 200, 1);
    if (!is_wr) exp_line = data;
    check("resp_o done", resp_o, 1);
    check("latency", lat, 5 + gaps_total);
    check("busy dropped in done", {254'd0, read_o, write_o}, 0);
    check("line_o", line_o, exp_line);
    if (!hold) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    // Memory noise while idle must be ignored.
    resp_i  = $urandom_range(1, 0);
    burst_i = {$urandom, $urandom};
    next_cycle();
    check("resp_o pulse width", resp_o, 0);
    check("no restart from done", {254'd0, read_o, write_o}, 0);
    check("line_o held", line_o, exp_line);
  endtask

  initial begin
    logic [255:0] l;
    vectors     = 0;
    miscompares = 0;
    exp_line    = '0;
    rst         = 1'b1;
    line_i      = '0;
    address_i   = '0;
    read_i      = 1'b0;
    write_i     = 1'b0;
    burst_i     = '0;
    resp_i      = 1'b0;
    next_cycle();
    next_cycle();
    check("rst resp_o", resp_o, 0);
    check("rst read_o", read_o, 0);
    check("rst write_o", write_o, 0);
    check("rst address_o", address_o, 0);
    check("rst burst_o", burst_o, 0);
    check("rst line_o", line_o, 0);
    rst = 1'b0;
    next_cycle();

    // Directed read, back-to-back beats.
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_txn(1'b0, 32'h0000_1234, l, 0, 0, 1'b0, 1'b0);
    // Directed write; line_o must keep the previous read line.
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_txn(1'b1, 32'h0000_1234, l, 0, 0, 1'b0, 1'b0);
    // Stalled read, two idle cycles before each beat.
    do_txn(1'b0, 32'hCAFE_F00D, rand_line(), 2, 2, 1'b0, 1'b0);
    // Request held through DONE, then a new read from the following IDLE cycle.
    do_txn(1'b0, 32'h8000_0040, rand_line(), 0, 1, 1'b1, 1'b0);
    do_txn(1'b0, 32'h8000_0060, rand_line(), 0, 1, 1'b0, 1'b0);

    // Reset after two read beats.
    address_i = 32'h0000_2000;
    read_i    = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      next_cycle();
    end
    resp_i  = 1'b0;
    rst     = 1'b1;
    read_i  = 1'b0;
    next_cycle();
    exp_line = '0;
    check("midrst read_o", read_o, 0);
    check("midrst resp_o", resp_o, 0);
    check("midrst address_o", address_o, 0);
    check("midrst burst_o", burst_o, 0);
    check("midrst line_o", line_o, 0);
    rst = 1'b0;
    next_cycle();
    do_txn(1'b0, 32'h0000_2000, rand_line(), 0, 0, 1'b0, 1'b0);

    // Both requests together: write path is taken.
    do_txn(1'b1, 32'h1357_9BDF, rand_line(), 0, 1, 1'b0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 24; n++) begin
      do_txn(1'($urandom_range(1, 0)), $urandom, rand_line(), 0, 3,
             ($urandom_range(3, 0) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
